// File: rtl/mem_link_pkg.sv
// ============================================================================
// Module      : mem_link_pkg
// Description : Memory-stream link word layout and sel-code decode, shared by
//               the transmit-side mux and the receive-side demux.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_link_pkg;

    localparam int BX_W    = 3;
    localparam int SEL_W   = 4;
    localparam int DAT_W   = 45;
    localparam int NPORTS  = 12;
    localparam int PORT_W  = 4;
    localparam int LINK_W  = BX_W + SEL_W + DAT_W;

    localparam int DAT_LSB = 0;
    localparam int SEL_LSB = DAT_W;
    localparam int BX_LSB  = DAT_W + SEL_W;

    localparam logic [SEL_W-1:0] SEL_IDLE = 4'b0000;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
        return ((sel >= 4'd1) && (sel <= 4'd9)) || ((sel >= 4'd11) && (sel <= 4'd13));
    endfunction

    // Code 10 is a hole in the map, so codes above it shift down by two.
    function automatic logic [PORT_W-1:0] sel_to_port(input logic [SEL_W-1:0] sel);
        if (sel <= 4'd9) return sel - 4'd1;
        return sel - 4'd2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_demux_addr_ctr.sv
// ============================================================================
// Module      : mem_demux_addr_ctr
// Description : Per-port write address counter with full flag and sticky
//               overflow; clr restarts the port in the same cycle as a write.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_demux_addr_ctr #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_ok,
    output logic              ovf
);

    localparam logic [ADDR_W-1:0] c_last = '1;

    logic [ADDR_W-1:0] r_ctr;
    logic              r_full;
    logic              r_ovf;

    logic [ADDR_W-1:0] w_ctr;
    logic              w_full;
    logic              w_ovf;

    assign w_ctr  = clr ? '0   : r_ctr;
    assign w_full = clr ? 1'b0 : r_full;
    assign w_ovf  = clr ? 1'b0 : r_ovf;

    assign addr  = w_ctr;
    assign wr_ok = wr && !w_full;
    assign ovf   = r_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctr  <= '0;
            r_full <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_ctr  <= w_ctr;
            r_full <= w_full;
            r_ovf  <= w_ovf || (wr && w_full);
            if (wr_ok) begin
                if (w_ctr == c_last) begin
                    r_ctr  <= '0;
                    r_full <= 1'b1;
                end else begin
                    r_ctr <= w_ctr + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_demux.sv
// ============================================================================
// Module      : mem_demux
// Description : Memory-stream link receiver demux: routes payloads to 12
//               destination memories with per-BX write addressing.
//               Optional MEM_DEMUX_STATS_EN adds the bx_nwords output.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_demux #(
    parameter int ADDR_W = 6,
    parameter int DAT_W  = 45
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [mem_link_pkg::LINK_W-1:0]               stream_in,
    input  logic                                          stream_valid,
    output logic [mem_link_pkg::NPORTS-1:0]               wr_en,
    output logic [mem_link_pkg::NPORTS*ADDR_W-1:0]        wr_addr,
    output logic [DAT_W-1:0]                              wr_dat,
    output logic [mem_link_pkg::BX_W-1:0]                 wr_bx,
    output logic                                          bx_start,
    output logic [mem_link_pkg::NPORTS-1:0]               ovf,
    output logic                                          sel_err
`ifdef MEM_DEMUX_STATS_EN
    ,
    output logic [ADDR_W+3:0]                             bx_nwords
`endif
);

    import mem_link_pkg::*;

    logic [BX_W-1:0]            w_bx;
    logic [SEL_W-1:0]           w_sel;
    logic [DAT_W-1:0]           w_dat;
    logic                       w_legal;
    logic                       w_new_bx;
    logic [PORT_W-1:0]          w_port;
    logic [NPORTS-1:0]          w_wr;
    logic [NPORTS-1:0]          w_wr_ok;
    logic [ADDR_W-1:0]          w_addr [NPORTS];

    logic [0:0]                 r_state;
    logic [BX_W-1:0]            r_cur_bx;
    logic [NPORTS-1:0]          r_wr_en;
    logic [NPORTS*ADDR_W-1:0]   r_wr_addr;
    logic [DAT_W-1:0]           r_wr_dat;
    logic [BX_W-1:0]            r_wr_bx;
    logic                       r_bx_start;
    logic                       r_sel_err;

    assign w_bx    = stream_in[BX_LSB +: BX_W];
    assign w_sel   = stream_in[SEL_LSB +: SEL_W];
    assign w_dat   = stream_in[DAT_LSB +: DAT_W];
    assign w_legal = stream_valid && sel_legal(w_sel);
    assign w_port  = sel_to_port(w_sel);

    // Any valid word opens a BX from IDLE, including idle and illegal codes.
    assign w_new_bx = stream_valid && ((r_state == ST_IDLE) || (w_bx != r_cur_bx));

    genvar p;
    generate
        for (p = 0; p < NPORTS; p++) begin : g_port
            assign w_wr[p] = w_legal && (w_port == PORT_W'(p));

            mem_demux_addr_ctr #(
                .ADDR_W (ADDR_W)
            ) u_ctr (
                .clk   (clk),
                .reset (reset),
                .clr   (w_new_bx),
                .wr    (w_wr[p]),
                .addr  (w_addr[p]),
                .wr_ok (w_wr_ok[p]),
                .ovf   (ovf[p])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cur_bx   <= '0;
            r_wr_en    <= '0;
            r_wr_addr  <= '0;
            r_wr_dat   <= '0;
            r_wr_bx    <= '0;
            r_bx_start <= 1'b0;
            r_sel_err  <= 1'b0;
        end else begin
            r_wr_en    <= w_wr_ok;
            for (int i = 0; i < NPORTS; i++) begin
                r_wr_addr[i*ADDR_W +: ADDR_W] <= w_addr[i];
            end
            if (|w_wr_ok) begin
                r_wr_dat <= w_dat;
                r_wr_bx  <= w_bx;
            end
            r_bx_start <= w_new_bx;
            r_sel_err  <= stream_valid && (w_sel != SEL_IDLE) && !sel_legal(w_sel);
            if (w_new_bx) begin
                r_state  <= ST_RUN;
                r_cur_bx <= w_bx;
            end
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_dat   = r_wr_dat;
    assign wr_bx    = r_wr_bx;
    assign bx_start = r_bx_start;
    assign sel_err  = r_sel_err;

`ifdef MEM_DEMUX_STATS_EN
    logic [ADDR_W+3:0] r_nwords;
    logic [ADDR_W+3:0] r_bx_nwords;

    // Legal words include drops to full ports.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_nwords    <= '0;
            r_bx_nwords <= '0;
        end else if (w_new_bx) begin
            r_bx_nwords <= r_nwords;
            r_nwords    <= w_legal ? (ADDR_W+4)'(1) : '0;
        end else if (w_legal) begin
            r_nwords <= r_nwords + 1'b1;
        end
    end

    assign bx_nwords = r_bx_nwords;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_demux.sv
// ============================================================================
// Module      : tb_mem_demux
// Description : Directed self-checking bench for mem_demux (ADDR_W = 2).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_demux;

    localparam int AW = 2;

    logic          clk;
    logic          reset;
    logic [51:0]   stream_in;
    logic          stream_valid;
    logic [11:0]   wr_en;
    logic [12*AW-1:0] wr_addr;
    logic [44:0]   wr_dat;
    logic [2:0]    wr_bx;
    logic          bx_start;
    logic [11:0]   ovf;
    logic          sel_err;
`ifdef MEM_DEMUX_STATS_EN
    logic [AW+3:0] bx_nwords;
`endif

    int n_chk = 0;
    int n_bad = 0;
    int n_err = 0;

    mem_demux #(
        .ADDR_W (AW),
        .DAT_W  (45)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stream_in    (stream_in),
        .stream_valid (stream_valid),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_dat       (wr_dat),
        .wr_bx        (wr_bx),
        .bx_start     (bx_start),
        .ovf          (ovf),
        .sel_err      (sel_err)
`ifdef MEM_DEMUX_STATS_EN
        ,
        .bx_nwords    (bx_nwords)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic v, input logic [2:0] bx, input logic [3:0] sel,
                        input logic [44:0] dat);
        @(negedge clk);
        stream_valid = v;
        stream_in    = {bx, sel, dat};
        @(posedge clk);
        #1;
        stream_valid = 1'b0;
    endtask

    function automatic logic [AW-1:0] fld(input int p);
        return wr_addr[p*AW +: AW];
    endfunction

    initial begin
        reset        = 1'b1;
        stream_valid = 1'b0;
        stream_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en",    64'(wr_en),    64'h0);
        check("rst_wr_addr",  64'(wr_addr),  64'h0);
        check("rst_wr_dat",   64'(wr_dat),   64'h0);
        check("rst_bx_start", 64'(bx_start), 64'h0);
        check("rst_ovf",      64'(ovf),      64'h0);
        check("rst_sel_err",  64'(sel_err),  64'h0);
`ifdef MEM_DEMUX_STATS_EN
        check("rst_nwords",   64'(bx_nwords), 64'h0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Three writes to port 0 in BX 2
        send(1'b1, 3'd2, 4'd1, 45'h11);
        check("t1_en0",    64'(wr_en),    64'h001);
        check("t1_addr0",  64'(fld(0)),   64'd0);
        check("t1_start0", 64'(bx_start), 64'h1);
        check("t1_bx",     64'(wr_bx),    64'd2);
        check("t1_dat",    64'(wr_dat),   64'h11);
        send(1'b1, 3'd2, 4'd1, 45'h12);
        check("t1_en1",    64'(wr_en),    64'h001);
        check("t1_addr1",  64'(fld(0)),   64'd1);
        check("t1_start1", 64'(bx_start), 64'h0);
        send(1'b1, 3'd2, 4'd1, 45'h13);
        check("t1_addr2",  64'(fld(0)),   64'd2);
        check("t1_start2", 64'(bx_start), 64'h0);

        // Port 11, then a BX change restarts it at 0
        send(1'b1, 3'd2, 4'd13, 45'h1ABC);
        check("t2_en",     64'(wr_en),    64'h800);
        check("t2_addr11", 64'(fld(11)),  64'd0);
        check("t2_dat",    64'(wr_dat),   64'h1ABC);
        check("t2_idle0",  64'(fld(0)),   64'd3);
        send(1'b1, 3'd3, 4'd13, 45'h2222);
        check("t2_en_b",   64'(wr_en),    64'h800);
        check("t2_addr_b", 64'(fld(11)),  64'd0);
        check("t2_start",  64'(bx_start), 64'h1);
        check("t2_bx",     64'(wr_bx),    64'd3);
        check("t2_clr0",   64'(fld(0)),   64'd0);

        // Illegal and idle sel codes
        send(1'b1, 3'd3, 4'd10, 45'h7);
        n_err += int'(sel_err);
        check("t3_en10",   64'(wr_en),    64'h0);
        send(1'b1, 3'd3, 4'd14, 45'h7);
        n_err += int'(sel_err);
        send(1'b1, 3'd3, 4'd15, 45'h7);
        n_err += int'(sel_err);
        check("t3_en15",   64'(wr_en),    64'h0);
        send(1'b1, 3'd3, 4'd0, 45'h7);
        check("t3_sel0",   64'(sel_err),  64'h0);
        check("t3_en0",    64'(wr_en),    64'h0);
        check("t3_nerr",   64'(n_err),    64'd3);
        check("t3_dathold", 64'(wr_dat),  64'h2222);
        send(1'b0, 3'd3, 4'd13, 45'h9);
        check("t3_novalid", 64'(wr_en),   64'h0);
        send(1'b1, 3'd3, 4'd13, 45'h33);
        check("t3_addr11", 64'(fld(11)),  64'd1);

        // Port 3 fills at depth 4, fifth word is dropped
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 3'd3, 4'd4, 45'(i));
            check("t4_en",   64'(wr_en),  64'h008);
            check("t4_addr", 64'(fld(3)), 64'(i));
        end
        check("t4_noovf",  64'(ovf),      64'h0);
        send(1'b1, 3'd3, 4'd4, 45'h44);
        check("t4_drop",   64'(wr_en),    64'h0);
        check("t4_ovf",    64'(ovf),      64'h008);
        check("t4_hold",   64'(fld(3)),   64'd0);
        send(1'b1, 3'd4, 4'd4, 45'h45);
        check("t4_newbx",  64'(wr_en),    64'h008);
        check("t4_addr0",  64'(fld(3)),   64'd0);
        check("t4_ovfclr", 64'(ovf),      64'h0);
        check("t4_start",  64'(bx_start), 64'h1);

        // Reset in mid-BX
        send(1'b1, 3'd4, 4'd7, 45'h51);
        send(1'b1, 3'd4, 4'd7, 45'h52);
        check("t5_addr6",  64'(fld(6)),   64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t5_rst_en",   64'(wr_en),   64'h0);
        check("t5_rst_addr", 64'(wr_addr), 64'h0);
        check("t5_rst_dat",  64'(wr_dat),  64'h0);
        check("t5_rst_bx",   64'(wr_bx),   64'h0);
        @(negedge clk);
        reset = 1'b0;
        send(1'b1, 3'd4, 4'd7, 45'h55);
        check("t5_en",     64'(wr_en),    64'h040);
        check("t5_addr",   64'(fld(6)),   64'd0);
        check("t5_start",  64'(bx_start), 64'h1);
        check("t5_bx",     64'(wr_bx),    64'd4);

        // Word statistics over BX 5
        send(1'b1, 3'd5, 4'd1, 45'h61);
        check("t6_start5", 64'(bx_start), 64'h1);
`ifdef MEM_DEMUX_STATS_EN
        check("t6_nw_prev", 64'(bx_nwords), 64'd1);
`endif
        send(1'b1, 3'd5, 4'd2, 45'h62);
        send(1'b1, 3'd5, 4'd3, 45'h63);
        send(1'b1, 3'd5, 4'd4, 45'h64);
        check("t6_en4",    64'(wr_en),    64'h008);
        send(1'b1, 3'd5, 4'd10, 45'h65);
        check("t6_err",    64'(sel_err),  64'h1);
        send(1'b1, 3'd6, 4'd0, 45'h66);
        check("t6_start6", 64'(bx_start), 64'h1);
        check("t6_en_idle", 64'(wr_en),   64'h0);
        check("t6_bxhold", 64'(wr_bx),    64'd5);
`ifdef MEM_DEMUX_STATS_EN
        check("t6_nwords", 64'(bx_nwords), 64'd4);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
